// File: rtl/alsu_cmd_issuer_pkg.sv
// Shared types for the ALSU command issuer: opcodes, control bundle,
// registered pin set, queued command and captured response records.
package alsu_cmd_issuer_pkg;

    localparam int TAG_W           = 4;
    localparam int DEF_CMD_DEPTH   = 4;
    localparam int DEF_RSP_DEPTH   = 4;
    localparam int DEF_CAPTURE_DLY = 3;

    typedef enum logic [2:0] {
        OP_OR        = 3'd0,
        OP_XOR       = 3'd1,
        OP_ADD       = 3'd2,
        OP_MULT      = 3'd3,
        OP_SHIFT     = 3'd4,
        OP_ROTATE    = 3'd5,
        OP_INVALID_6 = 3'd6,
        OP_INVALID_7 = 3'd7
    } opcode_e;

    typedef struct packed {
        logic cin;
        logic serial_in;
        logic direction;
        logic red_op_a;
        logic red_op_b;
        logic bypass_a;
        logic bypass_b;
    } alsu_ctrl_t;

    // Everything that is driven onto the ALSU input pins in one cycle.
    typedef struct packed {
        opcode_e    opcode;
        logic [2:0] a;
        logic [2:0] b;
        alsu_ctrl_t ctrl;
    } alsu_pins_t;

    typedef struct packed {
        alsu_pins_t       pins;
        logic [TAG_W-1:0] tag;
    } alsu_cmd_t;

    typedef struct packed {
        logic [5:0]       out;
        logic [TAG_W-1:0] tag;
    } alsu_rsp_t;

    // All-zero pins make the ALSU produce 0 on its output.
    localparam alsu_pins_t ALSU_NOP = '0;

endpackage

// File: rtl/alsu_cmd_issuer_if.sv
// Command and response handshake ports of the ALSU command issuer.
// The issuer itself is the slave; the producer/consumer side is the master.
interface alsu_cmd_issuer_if;
    import alsu_cmd_issuer_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    opcode_e          cmd_opcode;
    logic [2:0]       cmd_a;
    logic [2:0]       cmd_b;
    alsu_ctrl_t       cmd_ctrl;
    logic [TAG_W-1:0] cmd_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [5:0]       rsp_out;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_ctrl, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_out, rsp_tag
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_ctrl, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_out, rsp_tag
    );

endinterface

// File: rtl/alsu_cmd_issuer_sfifo.sv
// Small synchronous FIFO. Push is ignored when full and pop when empty;
// full/empty come from the registered count. The read port shows zero while
// empty so nothing stale is ever presented downstream.
module alsu_cmd_issuer_sfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full, empty, do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty;

    // Next pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and count state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the empty gate hides its contents.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/alsu_cmd_issuer.sv
// Feeds tagged commands to the ALSU one per cycle, follows each through the
// ALSU's fixed latency and queues the result with its tag, strictly in order.
// A command is only issued when the response FIFO is sure to have room for it
// (queued responses + in-flight commands < RSP_DEPTH), so capture never overflows.
module alsu_cmd_issuer
    import alsu_cmd_issuer_pkg::*;
#(
    parameter int CMD_DEPTH   = DEF_CMD_DEPTH,
    parameter int RSP_DEPTH   = DEF_RSP_DEPTH,
    parameter int CAPTURE_DLY = DEF_CAPTURE_DLY
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    alsu_cmd_issuer_if.slave bus,
    output logic [2:0]       alsu_opcode_o,
    output logic [2:0]       alsu_a_o,
    output logic [2:0]       alsu_b_o,
    output logic             alsu_cin_o,
    output logic             alsu_serial_in_o,
    output logic             alsu_direction_o,
    output logic             alsu_red_op_a_o,
    output logic             alsu_red_op_b_o,
    output logic             alsu_bypass_a_o,
    output logic             alsu_bypass_b_o,
    input  logic [5:0]       alsu_out_i
);
    localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
    localparam int RSP_CW = $clog2(RSP_DEPTH) + 1;
    localparam int CRW    = $clog2(RSP_DEPTH + CAPTURE_DLY + 1) + 1;

    alsu_cmd_t                         cmd_in, cmd_head;
    logic [CMD_CW-1:0]                 cmd_count;
    logic                              cmd_full, cmd_empty, cmd_push;
    alsu_rsp_t                         rsp_in, rsp_head;
    logic [RSP_CW-1:0]                 rsp_count;
    logic                              rsp_push, rsp_pop;
    logic [CRW-1:0]                    inflight_cnt;
    logic                              issue;
    alsu_pins_t                        alsu_q, alsu_d;
    logic [CAPTURE_DLY-1:0]            pipe_v_q, pipe_v_d;
    logic [CAPTURE_DLY-1:0][TAG_W-1:0] pipe_tag_q, pipe_tag_d;

    // ---- command side ----
    assign cmd_in.pins.opcode = bus.cmd_opcode;
    assign cmd_in.pins.a      = bus.cmd_a;
    assign cmd_in.pins.b      = bus.cmd_b;
    assign cmd_in.pins.ctrl   = bus.cmd_ctrl;
    assign cmd_in.tag         = bus.cmd_tag;

    assign cmd_full      = (cmd_count == CMD_CW'(CMD_DEPTH));
    assign cmd_empty     = (cmd_count == '0);
    assign bus.cmd_ready = !cmd_full;
    assign cmd_push      = bus.cmd_valid && !cmd_full;

    alsu_cmd_issuer_sfifo #(
        .WIDTH ($bits(alsu_cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (cmd_push),
        .wdata_i (cmd_in),
        .pop_i   (issue),
        .rdata_o (cmd_head),
        .count_o (cmd_count)
    );

    // Credit check: count of commands already holding a response slot.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < CAPTURE_DLY; i++) begin
            inflight_cnt = inflight_cnt + CRW'(pipe_v_q[i]);
        end
        issue = !cmd_empty && ((CRW'(rsp_count) + inflight_cnt) < CRW'(RSP_DEPTH));
    end

    // Pins take the popped command on issue, otherwise fall back to NOP.
    always_comb begin
        alsu_d = ALSU_NOP;
        if (issue) alsu_d = cmd_head.pins;
    end

    // Registered ALSU input pins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) alsu_q <= ALSU_NOP;
        else         alsu_q <= alsu_d;
    end

    assign alsu_opcode_o    = alsu_q.opcode;
    assign alsu_a_o         = alsu_q.a;
    assign alsu_b_o         = alsu_q.b;
    assign alsu_cin_o       = alsu_q.ctrl.cin;
    assign alsu_serial_in_o = alsu_q.ctrl.serial_in;
    assign alsu_direction_o = alsu_q.ctrl.direction;
    assign alsu_red_op_a_o  = alsu_q.ctrl.red_op_a;
    assign alsu_red_op_b_o  = alsu_q.ctrl.red_op_b;
    assign alsu_bypass_a_o  = alsu_q.ctrl.bypass_a;
    assign alsu_bypass_b_o  = alsu_q.ctrl.bypass_b;

    // In-flight pipe: stage 0 is loaded on the same edge as the pins, so the
    // last stage is valid exactly when alsu_out holds that command's result.
    always_comb begin
        pipe_v_d      = '0;
        pipe_tag_d    = '0;
        pipe_v_d[0]   = issue;
        pipe_tag_d[0] = cmd_head.tag;
        for (int i = 1; i < CAPTURE_DLY; i++) begin
            pipe_v_d[i]   = pipe_v_q[i-1];
            pipe_tag_d[i] = pipe_tag_q[i-1];
        end
    end

    // In-flight valid/tag state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_v_q   <= '0;
            pipe_tag_q <= '0;
        end else begin
            pipe_v_q   <= pipe_v_d;
            pipe_tag_q <= pipe_tag_d;
        end
    end

    // ---- response side ----
    assign rsp_push   = pipe_v_q[CAPTURE_DLY-1];
    assign rsp_in.out = alsu_out_i;
    assign rsp_in.tag = pipe_tag_q[CAPTURE_DLY-1];
    assign rsp_pop    = bus.rsp_valid && bus.rsp_ready;

    alsu_cmd_issuer_sfifo #(
        .WIDTH ($bits(alsu_rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rsp_push),
        .wdata_i (rsp_in),
        .pop_i   (rsp_pop),
        .rdata_o (rsp_head),
        .count_o (rsp_count)
    );

    assign bus.rsp_valid = (rsp_count != '0);
    assign bus.rsp_out   = rsp_head.out;
    assign bus.rsp_tag   = rsp_head.tag;

endmodule

// File: tb/tb_alsu_cmd_issuer.sv
// Bench for the ALSU command issuer. A stand-in ALSU (input register, output
// register, result function) closes the loop; the reference is an in-order
// queue of expected {result, tag} filled on every accepted command.
module tb_alsu_cmd_issuer;
    import alsu_cmd_issuer_pkg::*;

    localparam int RSP_DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alsu_cmd_issuer_if bus();

    logic [2:0]  alsu_opcode, alsu_a, alsu_b;
    logic        alsu_cin, alsu_serial_in, alsu_direction;
    logic        alsu_red_op_a, alsu_red_op_b, alsu_bypass_a, alsu_bypass_b;
    logic [5:0]  alsu_out;
    logic [15:0] pins;
    logic [15:0] alsu_in_q;

    alsu_cmd_issuer dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .bus              (bus),
        .alsu_opcode_o    (alsu_opcode),
        .alsu_a_o         (alsu_a),
        .alsu_b_o         (alsu_b),
        .alsu_cin_o       (alsu_cin),
        .alsu_serial_in_o (alsu_serial_in),
        .alsu_direction_o (alsu_direction),
        .alsu_red_op_a_o  (alsu_red_op_a),
        .alsu_red_op_b_o  (alsu_red_op_b),
        .alsu_bypass_a_o  (alsu_bypass_a),
        .alsu_bypass_b_o  (alsu_bypass_b),
        .alsu_out_i       (alsu_out)
    );

    assign pins = {alsu_opcode, alsu_a, alsu_b, alsu_cin, alsu_serial_in, alsu_direction,
                   alsu_red_op_a, alsu_red_op_b, alsu_bypass_a, alsu_bypass_b};

    // Stand-in ALSU result: real operators for ops 0-3, every other field
    // folded in so that each pin affects the observed value. NOP gives 0.
    function automatic logic [5:0] alsu_fn(input logic [2:0] op, input logic [2:0] a,
                                           input logic [2:0] b, input logic [6:0] ctrl);
        logic [5:0] base;
        case (op)
            3'd0:    base = {3'b000, a | b};
            3'd1:    base = {3'b000, a ^ b};
            3'd2:    base = 6'(a) + 6'(b) + 6'(ctrl[6]);
            3'd3:    base = 6'(a) * 6'(b);
            default: base = {a, b} ^ {op, op};
        endcase
        return base ^ ctrl[5:0];
    endfunction

    // Stand-in ALSU: one input register, one output register.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alsu_in_q <= '0;
            alsu_out  <= '0;
        end else begin
            alsu_in_q <= pins;
            alsu_out  <= alsu_fn(alsu_in_q[15:13], alsu_in_q[12:10], alsu_in_q[9:7], alsu_in_q[6:0]);
        end
    end

    typedef struct {
        logic [5:0]       out;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_acc    = 0;
    int   issued   = 0;
    int   popped   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock: account for the handshakes that the coming edge completes,
    // then advance to the next falling edge.
    task automatic tick();
        exp_t e;
        if (pins != 16'd0) issued++;
        check("credit_bound", 32'((issued - popped) <= RSP_DEPTH), 32'd1);
        if (bus.cmd_valid && bus.cmd_ready) begin
            e.out = alsu_fn(bus.cmd_opcode, bus.cmd_a, bus.cmd_b, bus.cmd_ctrl);
            e.tag = bus.cmd_tag;
            exp_q.push_back(e);
            n_acc++;
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            popped++;
            check("rsp_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rsp_out", 32'(bus.rsp_out), 32'(e.out));
                check("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
            end
        end
        @(negedge clk);
    endtask

    task automatic set_cmd(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                           input logic [6:0] ctrl, input logic [TAG_W-1:0] tag);
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = opcode_e'(op);
        bus.cmd_a      = a;
        bus.cmd_b      = b;
        bus.cmd_ctrl   = alsu_ctrl_t'(ctrl);
        bus.cmd_tag    = tag;
    endtask

    // Random command whose pins are never all zero, so an issue is visible.
    task automatic rand_cmd(input logic [TAG_W-1:0] tag);
        logic [2:0] op, a, b;
        logic [6:0] ctrl;
        op   = 3'($urandom_range(0, 7));
        a    = 3'($urandom_range(0, 7));
        b    = 3'($urandom_range(0, 7));
        ctrl = 7'($urandom_range(0, 127));
        if ({op, a, b, ctrl} == 16'd0) a = 3'd1;
        set_cmd(op, a, b, ctrl, tag);
    endtask

    task automatic wait_accept(input string tag);
        logic got;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            got = bus.cmd_ready;
            tick();
        end
        check(tag, 32'(got), 32'd1);
    endtask

    task automatic drain(input string tag);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int t = 0; t < 60 && exp_q.size() != 0; t++) tick();
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pins"},      32'(pins),          32'd0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_out"},   32'(bus.rsp_out),   32'd0);
        check({tag, "_rsp_tag"},   32'(bus.rsp_tag),   32'd0);
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_before;
        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = OP_OR;
        bus.cmd_a      = '0;
        bus.cmd_b      = '0;
        bus.cmd_ctrl   = '0;
        bus.cmd_tag    = '0;
        bus.rsp_ready  = 1'b0;

        repeat (3) @(negedge clk);
        check_idle_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Reset with three commands in flight: nothing of them may return.
        for (int i = 0; i < 3; i++) begin
            rand_cmd(4'(i + 1));
            tick();
        end
        bus.cmd_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrst");
        exp_q.delete();
        issued = 0;
        popped = 0;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        repeat (10) tick();
        check("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);

        // Single ADD 3+2, tag 5: pins after edge 1, NOP after edge 2, response after edge 4.
        bus.rsp_ready = 1'b0;
        set_cmd(3'd2, 3'd3, 3'd2, 7'd0, 4'd5);
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) begin
                check("add_pin_opcode", 32'(alsu_opcode), 32'd2);
                check("add_pin_a",      32'(alsu_a),      32'd3);
                check("add_pin_b",      32'(alsu_b),      32'd2);
            end
            if (k == 2) check("idle_nop_pins", 32'(pins), 32'd0);
            if (k < 4) begin
                check("add_early_valid", 32'(bus.rsp_valid), 32'd0);
            end else begin
                check("add_valid", 32'(bus.rsp_valid), 32'd1);
                check("add_out",   32'(bus.rsp_out),   32'd5);
                check("add_tag",   32'(bus.rsp_tag),   32'd5);
            end
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("add_popped", 32'(bus.rsp_valid), 32'd0);

        // Streaming: four back-to-back commands, responses on four consecutive cycles.
        for (int i = 1; i <= 4; i++) begin
            rand_cmd(4'(i));
            tick();
        end
        bus.cmd_valid = 1'b0;
        check("stream_not_yet", 32'(bus.rsp_valid), 32'd0);
        tick();
        for (int j = 1; j <= 4; j++) begin
            check("stream_valid", 32'(bus.rsp_valid), 32'd1);
            check("stream_tag",   32'(bus.rsp_tag),   32'(j));
            tick();
        end
        check("stream_done", 32'(bus.rsp_valid), 32'd0);

        // Backpressure: 4 issue, 4 more queue, then the command port closes.
        bus.rsp_ready = 1'b0;
        acc_before = n_acc;
        for (int i = 0; i < 8; i++) begin
            rand_cmd(4'(i + 8));
            wait_accept("bp_accept");
        end
        bus.cmd_valid = 1'b0;
        check("bp_accepted", 32'(n_acc - acc_before), 32'd8);
        check("bp_cmd_full", 32'(bus.cmd_ready), 32'd0);
        repeat (4) tick();
        check("bp_still_full", 32'(bus.cmd_ready), 32'd0);
        check("bp_issue_held", 32'(pins),          32'd0);
        check("bp_rsp_valid",  32'(bus.rsp_valid), 32'd1);

        // Full command FIFO: a waiting command is not taken while an issue pops.
        rand_cmd(4'd0);
        bus.rsp_ready = 1'b1;
        check("full_ready_a", 32'(bus.cmd_ready), 32'd0);
        tick();
        check("full_ready_b", 32'(bus.cmd_ready), 32'd0);
        tick();
        check("full_ready_c", 32'(bus.cmd_ready), 32'd1);
        wait_accept("full_accept");
        drain("bp_drain");

        // Randomized traffic against the in-order model.
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 99) < 60) rand_cmd(4'($urandom_range(0, 15)));
            else bus.cmd_valid = 1'b0;
            bus.rsp_ready = ($urandom_range(0, 99) < 70);
            tick();
        end
        drain("rand_drain");
        repeat (5) tick();
        check("final_idle_valid", 32'(bus.rsp_valid), 32'd0);
        check("final_idle_pins",  32'(pins),          32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
